// File: rtl/bpred_storage.sv
// bpred_storage: 256x32 instruction RAM and 256x36 byte-lane predictor RAM, 1-cycle registered reads.
// Define PRED_RDW_BYPASS_EN to make a same-address read during a write return the new data.
module bpred_storage #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int INSN_W = 32,
    parameter int LANE_W = 9
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                insn_wren,
    input  logic [ADDR_W-1:0]   insn_wraddress,
    input  logic [INSN_W-1:0]   insn_data,
    input  logic [ADDR_W-1:0]   insn_rdaddress,
    output logic [INSN_W-1:0]   insn_q,
    input  logic                pred_wren,
    input  logic [3:0]          pred_byteena,
    input  logic [ADDR_W-1:0]   pred_wraddress,
    input  logic [4*LANE_W-1:0] pred_data,
    input  logic [ADDR_W-1:0]   pred_rdaddress,
    output logic [4*LANE_W-1:0] pred_q
);
    localparam int PRED_W = 4*LANE_W;
    logic [INSN_W-1:0] insn_mem [DEPTH] = '{default: '0};
    logic [PRED_W-1:0] pred_mem [DEPTH] = '{default: '0};
    logic [INSN_W-1:0] insn_r = '0;
    logic [PRED_W-1:0] pred_r = '0;
    logic [INSN_W-1:0] insn_rd;
    logic [PRED_W-1:0] pred_rd;
`ifdef PRED_RDW_BYPASS_EN
    logic insn_hit, pred_hit;
    assign insn_hit = insn_wren && insn_wraddress == insn_rdaddress;
    assign pred_hit = pred_wren && pred_wraddress == pred_rdaddress;
    always_comb begin
        insn_rd = insn_hit ? insn_data : insn_mem[insn_rdaddress];
        pred_rd = pred_mem[pred_rdaddress];
        for (int i = 0; i < 4; i++)
            if (pred_hit && pred_byteena[i])
                pred_rd[i*LANE_W +: LANE_W] = pred_data[i*LANE_W +: LANE_W];
    end
`else
    assign insn_rd = insn_mem[insn_rdaddress];
    assign pred_rd = pred_mem[pred_rdaddress];
`endif
    // writes ignore reset so the bimodal table can be cleared while reset is held
    always_ff @(posedge clk) begin
        if (insn_wren)
            insn_mem[insn_wraddress] <= insn_data;
        for (int i = 0; i < 4; i++)
            if (pred_wren && pred_byteena[i])
                pred_mem[pred_wraddress][i*LANE_W +: LANE_W] <= pred_data[i*LANE_W +: LANE_W];
    end
    always_ff @(posedge clk) begin
        insn_r <= reset ? '0 : insn_rd;
        pred_r <= reset ? '0 : pred_rd;
    end
    assign insn_q = insn_r;
    assign pred_q = pred_r;
endmodule

// File: tb/tb_bpred_storage.sv
// tb_bpred_storage: directed vectors with hand-computed expectations for bpred_storage.
module tb_bpred_storage;
    logic        clk = 0;
    logic        reset;
    logic        insn_wren;
    logic [7:0]  insn_wraddress, insn_rdaddress;
    logic [31:0] insn_data, insn_q;
    logic        pred_wren;
    logic [3:0]  pred_byteena;
    logic [7:0]  pred_wraddress, pred_rdaddress;
    logic [35:0] pred_data, pred_q;
    int checks = 0;
    int errors = 0;

    bpred_storage dut (
        .clk(clk), .reset(reset),
        .insn_wren(insn_wren), .insn_wraddress(insn_wraddress), .insn_data(insn_data),
        .insn_rdaddress(insn_rdaddress), .insn_q(insn_q),
        .pred_wren(pred_wren), .pred_byteena(pred_byteena), .pred_wraddress(pred_wraddress),
        .pred_data(pred_data), .pred_rdaddress(pred_rdaddress), .pred_q(pred_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pwrite(input logic [7:0] a, input logic [35:0] d, input logic [3:0] be);
        pred_wren = 1; pred_wraddress = a; pred_data = d; pred_byteena = be;
        step();
        pred_wren = 0;
    endtask

    initial begin
        reset = 1;
        insn_wren = 0; insn_wraddress = 0; insn_data = 0; insn_rdaddress = 0;
        pred_wren = 0; pred_byteena = 0; pred_wraddress = 0; pred_data = 0; pred_rdaddress = 0;
        step();
        check("rst_insn", insn_q, 0);
        check("rst_pred", pred_q, 0);
        reset = 0;

        insn_wren = 1; insn_wraddress = 8'h12; insn_data = 32'hDEADBEEF;
        step();
        insn_wren = 0; insn_rdaddress = 8'h12;
        step();
        check("insn_rd", insn_q, 32'hDEADBEEF);

        // byte lanes at address 5
        pwrite(8'd5, 36'h123456789, 4'b1111);
        pwrite(8'd5, 36'h000000000, 4'b0001);
        pred_rdaddress = 8'd5;
        step();
        check("lane0_clr", pred_q, 36'h123456600);
        pwrite(8'd5, 36'h000000000, 4'b0000);
        step();
        check("be_none", pred_q, 36'h123456600);
        pwrite(8'd5, 36'hFFFFFFFFF, 4'b0100);
        step();
        check("lane2_set", pred_q, 36'h127FD6600);

        // clear lane 0 at 0..2 while reset is held
        for (int i = 0; i < 3; i++) pwrite(8'(i), 36'hABCDE01FF, 4'b1111);
        reset = 1;
        for (int i = 0; i < 3; i++) begin
            pred_wren = 1; pred_byteena = 4'b0001; pred_data = 0;
            pred_wraddress = 8'(i); pred_rdaddress = 8'(i);
            step();
            check("rst_pred_q", pred_q, 0);
            check("rst_insn_q", insn_q, 0);
        end
        reset = 0; pred_wren = 0;
        for (int i = 0; i < 3; i++) begin
            pred_rdaddress = 8'(i);
            step();
            check("post_clr", pred_q, 36'hABCDE0000);
        end

        // read-during-write
        insn_wren = 1; insn_wraddress = 8'd7; insn_data = 32'hAAAA5555;
        step();
        insn_data = 32'h0F0F0F0F; insn_rdaddress = 8'd7;
        pwrite(8'd9, 36'h111111111, 4'b1111);
        insn_wren = 0;
`ifdef PRED_RDW_BYPASS_EN
        check("rdw_insn", insn_q, 32'h0F0F0F0F);
`else
        check("rdw_insn", insn_q, 32'hAAAA5555);
`endif
        step();
        check("rdw_insn_after", insn_q, 32'h0F0F0F0F);
        pred_rdaddress = 8'd9;
        pwrite(8'd9, 36'h000000000, 4'b0011);
`ifdef PRED_RDW_BYPASS_EN
        check("rdw_pred", pred_q, 36'h111100000);
`else
        check("rdw_pred", pred_q, 36'h111111111);
`endif
        step();
        check("rdw_pred_after", pred_q, 36'h111100000);

        // independence and top address
        insn_wren = 1; insn_wraddress = 8'hFF; insn_data = 32'h13579BDF; insn_rdaddress = 8'h00;
        pred_rdaddress = 8'h00;
        pwrite(8'hFF, 36'hFEDCBA987, 4'b1111);
        insn_wren = 0;
        check("wrap_insn0", insn_q, 32'h0);
        check("wrap_pred0", pred_q, 36'hABCDE0000);
        insn_rdaddress = 8'hFF; pred_rdaddress = 8'hFF;
        step();
        check("top_insn", insn_q, 32'h13579BDF);
        check("top_pred", pred_q, 36'hFEDCBA987);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bpred_storage.md
# bpred_storage

Storage block for the branch-predictor front end: two independent simple-dual-port synchronous RAMs sharing one clock. The instruction RAM (256×32) feeds fetch. The predictor RAM (256×36, four 9-bit byte lanes) packs BTB target bits and the 2-bit bimodal counter. Both read ports are addressed from the fetch side; both write ports are driven from execute or loader logic, including a table clear that runs while reset is held.

## Interface
Parameters:
- ADDR_W, 8, address width of both RAMs
- DEPTH, 256, entries per RAM (2**ADDR_W)
- INSN_W, 32, instruction RAM word width
- LANE_W, 9, predictor RAM byte-lane width; predictor word = 4×LANE_W = 36

Ports:
- clk  in  1  single clock; all activity on rising edge
- reset  in  1  reset is synchronous and active-high
- insn_wren  in  1  instruction RAM write enable
- insn_wraddress  in  ADDR_W  instruction write address
- insn_data  in  INSN_W  instruction write data
- insn_rdaddress  in  ADDR_W  instruction read address
- insn_q  out  INSN_W  instruction read data
- pred_wren  in  1  predictor RAM write enable
- pred_byteena  in  4  per-lane write enable; lane k = bits [9k+8:9k]
- pred_wraddress  in  ADDR_W  predictor write address
- pred_data  in  36  predictor write data
- pred_rdaddress  in  ADDR_W  predictor read address
- pred_q  out  36  predictor read data

## Operation
- Write, instruction RAM: when insn_wren=1 at a rising edge, the RAM stores mem[insn_wraddress] <= insn_data.
- Write, predictor RAM: when pred_wren=1 at a rising edge, the RAM updates each lane k with pred_byteena[k]=1 from pred_data. Lanes with a 0 enable keep their old contents.
- pred_byteena=0000 with pred_wren=1 leaves the entry unchanged.
- Writes are honoured regardless of reset. The external reset sequencer clears the bimodal table this way during reset.
- Read: on every rising edge, each RAM loads its output register from mem[rdaddress] as presented before that edge.
- Reset: while reset=1 at an edge, insn_q and pred_q load 0.
  - Reset does not alter RAM contents.
  - No read-enable or stall input; outputs update every cycle.
- Power-up: all RAM entries and both output registers are initialised to 0.
- Read-during-write to the same address in the same cycle returns the old (pre-write) data, unless the feature in Configuration is enabled.
- The two RAMs are fully independent. Simultaneous activity on both is always legal.
- Address values are taken modulo DEPTH; no out-of-range condition exists.

## Timing
- Read latency is 1 cycle:
  - address presented in cycle n;
  - data visible on q after edge n+1;
  - q is held until the next edge.
- Write latency is 1 cycle. Data written at edge n is readable by a read whose address is presented in cycle n+1, with q valid after edge n+2.
- Reset mid-operation: q is forced to 0 on the first edge with reset=1. Valid RAM data returns on the first edge after reset deasserts, i.e. 1 cycle after deassertion.
- No combinational path from any input to any output.

## Configuration
- Macro PRED_RDW_BYPASS_EN.
- When defined, a same-cycle read and write to the same address returns the new data:
  - predictor RAM: per lane, enabled lanes show pred_data and disabled lanes show stored data;
  - instruction RAM: the whole word shows insn_data.
- When undefined, the old-data behaviour above applies.

## Test plan
- Instruction path: write 0xDEADBEEF at address 0x12. Next cycle read 0x12 → insn_q=0xDEADBEEF one edge after the read address is applied.
- Byte lanes:
  - write pred_data=0x123456789 with byteena=1111 at address 5;
  - then write 0x000000000 with byteena=0001 at address 5;
  - read → pred_q=0x123456600, with only lane 0 (bits 8:0) cleared.
- Reset clear:
  - hold reset 3 cycles while writing 0 with byteena=0001 at addresses 0..2, after those entries were preset to 0x1FF in lane 0;
  - pred_q=0 during reset;
  - after release, reads return lane 0 = 0 at 0..2 and upper lanes unchanged.
- Read-during-write: address 7 holds 0xAAAA5555; write 0x0F0F0F0F to 7 while reading 7.
  - Macro undefined → insn_q=0xAAAA5555.
  - PRED_RDW_BYPASS_EN defined → 0x0F0F0F0F.
- Independence and wrap: write insn and pred at address 0xFF while reading address 0x00 on both RAMs → both return power-up/previous contents of 0x00 unaffected. A following read of 0xFF returns the written values.
